seven_seg_scanner: RTL and testbench

//   Time-multiplexes the three 7-bit digit patterns (hundreds, tens, ones) from the

---
 rtl/seven_seg_scanner.sv | 142 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexes three 7-bit digit patterns (hundreds, tens, ones) onto one
//   shared segment bus with a one-hot digit enable. New patterns are staged on
//   a load strobe and only copied into the displayed (shadow) set when the scan
//   wraps from hundreds back to ones, so a frame never mixes old and new digits.
//   Leading-zero digits are blanked; the ones digit is always shown.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   en         : scan enable; 0 freezes the scan and blanks the display
//   load       : 1-cycle strobe capturing h_seg/t_seg/o_seg into staging
//   h_seg      : hundreds pattern
//   t_seg      : tens pattern
//   o_seg      : ones pattern
//   seg        : shared segment bus (registered, 1 = lit)
//   an         : one-hot digit enable (registered); [0]=ones [1]=tens [2]=hundreds
//   frame_done : registered 1-cycle pulse on the hundreds->ones wrap
module seven_seg_scanner #(
  parameter int         DWELL    = 4,
  parameter int         CNT_W    = 16,
  parameter logic [6:0] ZERO_PAT = 7'b1111110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [6:0] h_seg,
  input  logic [6:0] t_seg,
  input  logic [6:0] o_seg,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dig;
  logic [6:0]       r_stage_h, r_stage_t, r_stage_o;
  logic             r_pend;
  logic [6:0]       r_shadow_h, r_shadow_t, r_shadow_o;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;
  logic             r_frame_done;

  logic             w_last;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_next;
  logic [1:0]       w_dig_next;
  logic [6:0]       w_sh_h_next, w_sh_t_next, w_sh_o_next;
  logic [6:0]       w_seg_next;
  logic [2:0]       w_an_next;

  // Next-state values for an enabled edge; outputs are derived from the
  // post-edge digit index and shadow so they line up with the state.
  always_comb begin
    w_last      = (r_cnt == LAST_CNT);
    w_wrap      = w_last && (r_dig == 2'd2);
    w_cnt_next  = w_last ? '0 : r_cnt + 1'b1;
    w_dig_next  = r_dig;
    if (w_last) w_dig_next = (r_dig == 2'd2) ? 2'd0 : r_dig + 2'd1;

    w_sh_h_next = r_shadow_h;
    w_sh_t_next = r_shadow_t;
    w_sh_o_next = r_shadow_o;
    if (w_wrap && r_pend) begin
      w_sh_h_next = r_stage_h;
      w_sh_t_next = r_stage_t;
      w_sh_o_next = r_stage_o;
    end

    w_an_next  = 3'b000;
    w_seg_next = 7'd0;
    case (w_dig_next)
      2'd0: begin
        w_an_next  = 3'b001;
        w_seg_next = w_sh_o_next;
      end
      2'd1: begin
        w_an_next  = 3'b010;
        // Tens is a leading zero only when hundreds is also zero.
        w_seg_next = ((w_sh_h_next == ZERO_PAT) && (w_sh_t_next == ZERO_PAT))
                     ? 7'd0 : w_sh_t_next;
      end
      2'd2: begin
        w_an_next  = 3'b100;
        w_seg_next = (w_sh_h_next == ZERO_PAT) ? 7'd0 : w_sh_h_next;
      end
      default: begin
        w_an_next  = 3'b000;
        w_seg_next = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dig        <= 2'd0;
      r_stage_h    <= 7'd0;
      r_stage_t    <= 7'd0;
      r_stage_o    <= 7'd0;
      r_pend       <= 1'b0;
      r_shadow_h   <= 7'd0;
      r_shadow_t   <= 7'd0;
      r_shadow_o   <= 7'd0;
      r_seg        <= 7'd0;
      r_an         <= 3'b000;
      r_frame_done <= 1'b0;
    end else begin
      if (en) begin
        r_cnt        <= w_cnt_next;
        r_dig        <= w_dig_next;
        r_shadow_h   <= w_sh_h_next;
        r_shadow_t   <= w_sh_t_next;
        r_shadow_o   <= w_sh_o_next;
        r_an         <= w_an_next;
        r_seg        <= w_seg_next;
        r_frame_done <= w_wrap;
        if (w_wrap) r_pend <= 1'b0;
      end else begin
        r_an         <= 3'b000;
        r_seg        <= 7'd0;
        r_frame_done <= 1'b0;
      end
      // A load on the wrap edge wins over the clear above: the new value
      // stays pending for the following frame.
      if (load) begin
        r_stage_h <= h_seg;
        r_stage_t <= t_seg;
        r_stage_o <= o_seg;
        r_pend    <= 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;

  localparam int         DWELL = 4;
  localparam int         FRAME = 3 * DWELL;
  localparam logic [6:0] ZP    = 7'b1111110;
  localparam logic [6:0] ONE   = 7'b0110000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [6:0] h_seg, t_seg, o_seg;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_done;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: position within the frame (0..FRAME-1) plus digit sets.
  int         m_pos;
  logic [6:0] m_stage [3];   // [0]=ones [1]=tens [2]=hundreds
  logic [6:0] m_shadow[3];
  bit         m_pend;
  logic [6:0] e_seg;
  logic [2:0] e_an;
  logic       e_fd;

  seven_seg_scanner #(.DWELL(DWELL), .CNT_W(16), .ZERO_PAT(ZP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load),
    .h_seg(h_seg), .t_seg(t_seg), .o_seg(o_seg),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] shown(int d);
    if (d == 0) return m_shadow[0];
    if (d == 1) return (m_shadow[2] == ZP && m_shadow[1] == ZP) ? 7'd0 : m_shadow[1];
    return (m_shadow[2] == ZP) ? 7'd0 : m_shadow[2];
  endfunction

  task automatic model_reset();
    m_pos  = 0;
    m_pend = 0;
    for (int i = 0; i < 3; i++) begin
      m_stage[i]  = 7'd0;
      m_shadow[i] = 7'd0;
    end
    e_seg = 7'd0; e_an = 3'b000; e_fd = 1'b0;
  endtask

  task automatic check(string tag, logic [6:0] got, logic [6:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".seg"}, seg, e_seg);
    check({tag, ".an"}, {4'd0, an}, {4'd0, e_an});
    check({tag, ".fd"}, {6'd0, frame_done}, {6'd0, e_fd});
  endtask

  // One clock edge: drive inputs, advance the model, sample after the edge.
  task automatic step(string tag, bit e, bit l, logic [6:0] h, logic [6:0] t, logic [6:0] o);
    bit wrap;
    en = e; load = l; h_seg = h; t_seg = t; o_seg = o;
    if (e) begin
      wrap = (m_pos == FRAME - 1);
      if (wrap) begin
        if (m_pend) for (int i = 0; i < 3; i++) m_shadow[i] = m_stage[i];
        m_pend = 0;
      end
      m_pos = (m_pos + 1) % FRAME;
      e_an  = 3'(1 << (m_pos / DWELL));
      e_seg = shown(m_pos / DWELL);
      e_fd  = wrap;
    end else begin
      e_an = 3'b000; e_seg = 7'd0; e_fd = 1'b0;
    end
    if (l) begin
      m_stage[2] = h; m_stage[1] = t; m_stage[0] = o; m_pend = 1;
    end
    @(posedge clk); #1;
    check_all(tag);
    load = 1'b0;
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0);
  endtask

  // Advance until the model sits at the given frame position (bounded).
  task automatic run_to(string tag, int pos);
    for (int i = 0; i < 2 * FRAME && m_pos != pos; i++)
      step(tag, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0;
    h_seg = 7'd0; t_seg = 7'd0; o_seg = 7'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Free-running scan with blank shadow
    idle("scan", 2 * FRAME);

    // Leading zeros blanked: 001
    step("load1", 1'b1, 1'b1, ZP, ZP, ONE);
    run_to("wait1", 0);
    idle("show1", FRAME + 2);

    // Mid-frame load: 100, tens not blanked
    run_to("mid2", DWELL + 1);
    step("load2", 1'b1, 1'b1, ONE, ZP, ZP);
    idle("show2", 2 * FRAME);

    // Load on the wrap edge, with an earlier value already pending
    step("load3a", 1'b1, 1'b1, 7'b1011011, ZP, 7'b0000001);
    run_to("mid3", FRAME - 1);
    step("load3b", 1'b1, 1'b1, ZP, 7'b1111001, ONE);
    idle("show3", 2 * FRAME + 1);

    // Load on the wrap edge with nothing pending
    run_to("mid4", FRAME - 1);
    step("load4", 1'b1, 1'b1, 7'b0110011, 7'b1011011, ZP);
    idle("show4", 2 * FRAME);

    // Freeze after two cycles of tens dwell, with a load while frozen
    run_to("mid5", DWELL + 1);
    for (int i = 0; i < 5; i++) step("frozen", 1'b0, (i == 2), 7'b1110000, ZP, ONE);
    idle("resume", FRAME + 3);

    // Mid-frame reset with a pending load
    step("load6", 1'b1, 1'b1, ONE, ONE, ONE);
    idle("pre6", 3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle("post6", 2 * FRAME);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [6:0] rh, rt, ro;
      rh = ($urandom_range(0, 2) == 0) ? ZP : 7'($urandom);
      rt = ($urandom_range(0, 2) == 0) ? ZP : 7'($urandom);
      ro = 7'($urandom);
      step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0), rh, rt, ro);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
